reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports m0_req / m1_req  input  1  access request from master 0 / master 1; held high until that master's done.
REQ-004 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read; held stable while req is high.
REQ-005 SHALL have ports m0_addr / m1_addr  input  6  register address; held stable while req is high.
REQ-006 SHALL have ports m0_wdata / m1_wdata  input  8  write data; held stable while req is high.
REQ-007 SHALL have ports m0_gnt / m1_gnt  output  1  high only during that master's ACCESS cycle.
REQ-008 SHALL have ports m0_rdata / m1_rdata  output  8  captured read data; valid while that master's done is high.
REQ-009 SHALL have ports m0_done / m1_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port read  output  1  register-file read strobe.
REQ-011 SHALL have port write  output  1  register-file write strobe.
REQ-012 SHALL have port addr  output  6  register-file address.
REQ-013 SHALL have port data_write  output  8  register-file write data.
REQ-014 SHALL have port data_read  input  8  combinational register-file read data.

Function
REQ-015 SHALL implement the FSM IDLE -> ACCESS -> DONE -> IDLE, with one state per cycle.
REQ-016 SHALL, in IDLE, leave IDLE for ACCESS when an eligible request is high, and otherwise stay in IDLE.
REQ-017 SHALL, in DONE, ignore all requests.
REQ-018 SHALL give a request sampled high in IDLE at cycle N its ACCESS at N+1 and its done at N+2, so throughput is one access per 3 cycles.
REQ-019 SHALL drive all bus outputs from registers: in ACCESS, addr = granted master's addr; write = we, data_write = wdata when writing; read = ~we; in all other states every bus output SHALL be 0.
REQ-020 SHALL capture data_read at the end of a read ACCESS cycle into the granted master's rdata, which SHALL hold until that master's next read completes.
REQ-021 SHALL keep a write ACCESS from altering rdata.
REQ-022 SHALL arbitrate round-robin with a 1-bit pointer: when both masters request, the non-pointer master wins; after a master completes, the pointer points to that master.
REQ-023 SHALL give a lone request the grant regardless of the pointer.
REQ-024 SHALL assert exactly one of m0_gnt/m1_gnt in ACCESS, and SHALL never assert m0_done and m1_done in the same cycle.
REQ-025 SHALL treat a request that falls before done as a protocol violation; the access still completes unchanged.

Reset
REQ-026 SHALL, while rst_n is low and regardless of clk, hold state=IDLE, pointer=1 (master 0 wins first tie), read=write=0, addr=0, data_write=0, gnt=0, done=0, rdata=0x00, lock cleared, timeout counter=0.
REQ-027 SHALL abort an access cut by reset mid-ACCESS: the strobe drops immediately and no done pulse is produced.

Configuration
REQ-028 SHALL, with ARB_PAIR_LOCK_EN defined, set a lock owned by master k when k completes a write to a low-byte address (0x00, 0x03, 0x05).
REQ-029 SHALL, while locked, make only the owner eligible.
REQ-030 SHALL clear the lock when the owner completes any further access.
REQ-031 SHALL clear the lock when a 4-bit timeout counter expires: the counter counts cycles in IDLE with the owner not requesting and clears when the lock clears; at the count of 16 the lock releases and normal round-robin resumes the next cycle.
REQ-032 SHALL, with ARB_PAIR_LOCK_EN undefined, omit the lock and counter logic and arbitrate purely round-robin.

Verification
REQ-033 SHALL cover: after reset, m0 write 0x0A/0x05 at cycle 0 -> write=1, addr=0x0A, data_write=0x05 at cycle 1 only; m0_done at cycle 2.
REQ-034 SHALL cover: m1 read 0x02, data_read=0x01 -> read=1 at cycle 1; m1_rdata=0x01 with m1_done at cycle 2; m0_rdata unchanged.
REQ-035 SHALL cover: both masters requesting continuously from reset -> grant order 0,1,0,1, one done every 3 cycles.
REQ-036 SHALL cover, with the macro: m1 writes 0x03, then m0 and m1 request together -> m1 granted first for 0x04, then m0; without the macro -> m0 first.
REQ-037 SHALL cover, with the macro: m0 writes 0x00, m0 silent, m1 requesting -> m1 ACCESS only after the 16-cycle timeout; without the macro -> m1 ACCESS on the next IDLE.
REQ-038 SHALL cover: rst_n pulsed low during a write ACCESS -> write=0 immediately, no done, next access behaves as in REQ-033.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter onto a single-cycle register-file bus (IDLE -> ACCESS -> DONE).
// Define ARB_PAIR_LOCK_EN to add the write-to-pair-address lock with a 16-cycle idle timeout.
module reg_bus_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [5:0] m0_addr,
  input  logic [7:0] m0_wdata,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [5:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m0_gnt,
  output logic       m1_gnt,
  output logic [7:0] m0_rdata,
  output logic [7:0] m1_rdata,
  output logic       m0_done,
  output logic       m1_done,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e     state_q;
  logic       ptr_q;
  logic       sel_q;
  logic [1:0] gnt_q;
  logic [1:0] done_q;
  logic [7:0] rdata0_q;
  logic [7:0] rdata1_q;
  logic       read_q;
  logic       write_q;
  logic [5:0] addr_q;
  logic [7:0] wdata_q;

  logic [1:0] req;
  logic [1:0] elig;
  logic       win_valid;
  logic       win;
  logic       sel_we;
  logic [5:0] sel_addr;
  logic [7:0] sel_wdata;

  assign req = {m1_req, m0_req};

`ifdef ARB_PAIR_LOCK_EN
  logic       lock_q;
  logic       owner_q;
  logic [3:0] tmo_q;
  logic       owner_req;
  logic       lock_hit;

  assign owner_req = owner_q ? m1_req : m0_req;
  assign lock_hit  = write_q && ((addr_q == 6'h00) || (addr_q == 6'h03) || (addr_q == 6'h05));

  always_comb begin
    elig = req;
    if (lock_q) begin
      elig = owner_q ? (req & 2'b10) : (req & 2'b01);
    end
  end

  // Only the owner can be granted while locked, so any completion under lock is the owner's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      tmo_q   <= 4'd0;
    end else if (state_q == StAccess) begin
      if (lock_q) begin
        lock_q <= 1'b0;
        tmo_q  <= 4'd0;
      end else if (lock_hit) begin
        lock_q  <= 1'b1;
        owner_q <= sel_q;
        tmo_q   <= 4'd0;
      end
    end else if (lock_q && (state_q == StIdle) && !owner_req) begin
      if (tmo_q == 4'hF) begin
        lock_q <= 1'b0;
        tmo_q  <= 4'd0;
      end else begin
        tmo_q <= tmo_q + 4'd1;
      end
    end
  end
`else
  assign elig = req;
`endif

  // Tie goes to the master the pointer does not name.
  always_comb begin
    win_valid = |elig;
    win       = 1'b0;
    case (elig)
      2'b10:   win = 1'b1;
      2'b11:   win = ~ptr_q;
      default: win = 1'b0;
    endcase
  end

  assign sel_we    = win ? m1_we    : m0_we;
  assign sel_addr  = win ? m1_addr  : m0_addr;
  assign sel_wdata = win ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b1;
      sel_q    <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= 6'h00;
      wdata_q  <= 8'h00;
    end else begin
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 6'h00;
      wdata_q <= 8'h00;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q <= StAccess;
            sel_q   <= win;
            gnt_q   <= win ? 2'b10 : 2'b01;
            addr_q  <= sel_addr;
            write_q <= sel_we;
            read_q  <= ~sel_we;
            wdata_q <= sel_we ? sel_wdata : 8'h00;
          end
        end
        StAccess: begin
          state_q <= StDone;
          done_q  <= sel_q ? 2'b10 : 2'b01;
          ptr_q   <= sel_q;
          if (read_q) begin
            if (sel_q) begin
              rdata1_q <= data_read;
            end else begin
              rdata0_q <= data_read;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m0_gnt     = gnt_q[0];
  assign m1_gnt     = gnt_q[1];
  assign m0_done    = done_q[0];
  assign m1_done    = done_q[1];
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign data_write = wdata_q;

`ifndef SYNTHESIS
  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StAccess) |-> $onehot({m1_gnt, m0_gnt}));

  done_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(m0_done && m1_done));

  // A master dropping req before its done is a protocol violation; the access still completes.
  req_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != StIdle) |-> (sel_q ? m1_req : m0_req))
    else $error("reg_bus_arbiter: master %0d dropped req before done", sel_q);
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: scenarios queue master commands plus the expected bus
// access and completion (master, cycle, strobes, rdata); a negedge monitor pops and compares.
module tb_reg_bus_arbiter;

  typedef struct {
    bit         we;
    logic [5:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef struct {
    bit          m;
    bit          we;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int unsigned acc;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [5:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_gnt, m1_gnt, m0_done, m1_done;
  logic [7:0] m0_rdata, m1_rdata;
  logic       read, write;
  logic [5:0] addr;
  logic [7:0] data_write, data_read;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  bit          abort = 1'b0;
  logic [7:0]  mdl_rdata [2];

  cmd_t  cmd0_q [$];
  cmd_t  cmd1_q [$];
  item_t exp_acc_q [$];
  item_t exp_done_q [$];

  reg_bus_arbiter u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m0_gnt     (m0_gnt),
    .m1_gnt     (m1_gnt),
    .m0_rdata   (m0_rdata),
    .m1_rdata   (m1_rdata),
    .m0_done    (m0_done),
    .m1_done    (m1_done),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_write (data_write),
    .data_read  (data_read)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file stand-in: fixed contents, read data = address ^ 3.
  assign data_read = {2'b00, addr} ^ 8'h03;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input bit m, input bit we, input logic [5:0] a, input logic [7:0] wd,
                      input int unsigned acc);
    cmd_t  c;
    item_t it;
    c.we = we; c.addr = a; c.wdata = wd;
    it.m = m; it.we = we; it.addr = a; it.wdata = wd; it.acc = acc;
    it.rdata = {2'b00, a} ^ 8'h03;
    if (m) cmd1_q.push_back(c);
    else   cmd0_q.push_back(c);
    exp_acc_q.push_back(it);
  endtask

  task automatic do_reset();
    abort = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("reset_outputs",
             {m0_gnt, m1_gnt, m0_done, m1_done, read, write, addr, data_write, m0_rdata, m1_rdata},
             64'd0);
    exp_acc_q.delete();
    exp_done_q.delete();
    cmd0_q.delete();
    cmd1_q.delete();
    mdl_rdata[0] = 8'h00;
    mdl_rdata[1] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_acc_q.size() + exp_done_q.size() + cmd0_q.size() + cmd1_q.size()) != 0 &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_pending", 64'(exp_acc_q.size() + exp_done_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Master agents: raise req for the next queued command, drop it the cycle after done.
  initial begin
    bit [1:0] pend = 2'b00;
    cmd_t c;
    forever begin
      @(posedge clk);
      #1;
      if (abort) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
        pend   = 2'b00;
      end else begin
        if (m0_req && pend[0]) m0_req = 1'b0;
        if (!m0_req && cmd0_q.size() > 0) begin
          c = cmd0_q.pop_front();
          m0_we = c.we; m0_addr = c.addr; m0_wdata = c.wdata; m0_req = 1'b1;
        end
        if (m1_req && pend[1]) m1_req = 1'b0;
        if (!m1_req && cmd1_q.size() > 0) begin
          c = cmd1_q.pop_front();
          m1_we = c.we; m1_addr = c.addr; m1_wdata = c.wdata; m1_req = 1'b1;
        end
        pend = {m1_done, m0_done};
      end
    end
  end

  always @(negedge clk) begin
    item_t it;
    item_t d;
    if (rst_n) begin
      if (m0_gnt || m1_gnt || read || write) begin
        if (exp_acc_q.size() == 0) begin
          check_eq("unexp_bus", {m1_gnt, m0_gnt, read, write}, 64'd0);
        end else begin
          it = exp_acc_q.pop_front();
          check_eq("acc_cycle", cyc, it.acc);
          check_eq("gnt", {m1_gnt, m0_gnt}, it.m ? 2'b10 : 2'b01);
          check_eq("strobes", {read, write}, {~it.we, it.we});
          check_eq("addr", addr, it.addr);
          check_eq("data_write", data_write, it.we ? it.wdata : 8'h00);
          exp_done_q.push_back(it);
        end
      end else begin
        check_eq("bus_idle", {addr, data_write}, 64'd0);
      end
      if (m0_done || m1_done) begin
        check_eq("done_excl", m0_done & m1_done, 64'd0);
        if (exp_done_q.size() == 0) begin
          check_eq("unexp_done", {m1_done, m0_done}, 64'd0);
        end else begin
          d = exp_done_q.pop_front();
          check_eq("done_cycle", cyc, d.acc + 1);
          check_eq("done_who", {m1_done, m0_done}, d.m ? 2'b10 : 2'b01);
          if (!d.we) mdl_rdata[d.m] = d.rdata;
          check_eq("m0_rdata", m0_rdata, mdl_rdata[0]);
          check_eq("m1_rdata", m1_rdata, mdl_rdata[1]);
        end
      end
    end
  end

  initial begin
    int unsigned t0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 6'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 6'h00; m1_wdata = 8'h00;
    rst_n = 1'b1;

    // Lone write, then lone read into m1 leaving m0_rdata untouched.
    do_reset();
    @(negedge clk); #1; t0 = cyc;
    push(1'b0, 1'b1, 6'h0A, 8'h05, t0 + 2);
    wait_drain(20);
    t0 = cyc;
    push(1'b1, 1'b0, 6'h02, 8'h00, t0 + 2);
    wait_drain(20);

    // Both masters requesting back to back: 0,1,0,1 every 3 cycles.
    do_reset();
    @(negedge clk); #1; t0 = cyc;
    push(1'b0, 1'b1, 6'h11, 8'hA5, t0 + 2);
    push(1'b1, 1'b0, 6'h20, 8'h00, t0 + 5);
    push(1'b0, 1'b1, 6'h12, 8'h5A, t0 + 8);
    push(1'b1, 1'b0, 6'h21, 8'h00, t0 + 11);
    wait_drain(40);

    // m1 writes a pair address, then both request together.
    do_reset();
    @(negedge clk); #1; t0 = cyc;
    push(1'b1, 1'b1, 6'h03, 8'h77, t0 + 2);
    repeat (2) @(negedge clk);
    #1;
`ifdef ARB_PAIR_LOCK_EN
    push(1'b1, 1'b0, 6'h04, 8'h00, t0 + 5);
    push(1'b0, 1'b0, 6'h10, 8'h00, t0 + 8);
`else
    push(1'b0, 1'b0, 6'h10, 8'h00, t0 + 5);
    push(1'b1, 1'b0, 6'h04, 8'h00, t0 + 8);
`endif
    wait_drain(40);

    // m0 writes a pair address then goes silent while m1 waits.
    do_reset();
    @(negedge clk); #1; t0 = cyc;
    push(1'b0, 1'b1, 6'h00, 8'h3C, t0 + 2);
    repeat (2) @(negedge clk);
    #1;
`ifdef ARB_PAIR_LOCK_EN
    push(1'b1, 1'b0, 6'h05, 8'h00, t0 + 21);
`else
    push(1'b1, 1'b0, 6'h05, 8'h00, t0 + 5);
`endif
    wait_drain(60);

    // Reset pulsed mid-ACCESS: strobe drops at once, no done, next access is normal.
    do_reset();
    @(negedge clk); #1; t0 = cyc;
    push(1'b0, 1'b1, 6'h0A, 8'h05, t0 + 2);
    repeat (2) @(negedge clk);
    #2;
    check_eq("pre_abort_write", write, 64'd1);
    do_reset();
    check_eq("abort_write", write, 64'd0);
    repeat (4) @(negedge clk);
    #1; t0 = cyc;
    push(1'b0, 1'b1, 6'h0A, 8'h05, t0 + 2);
    wait_drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
